// File: rtl/alpu_xrx_cache.sv
// alpu_xrx_cache: multi-channel foreign (X) operand receive buffer.
// A shared, fully associative store of DEPTH {valid, addr, data} entries.
// Up to N_WCH interconnect channels can write to it, and N_RD read ports look
// up entries by operand address.
//
// Handshake: a write on channel k transfers when w_valid_i[k] & w_ready_o[k]
// are both high at a rising clock edge. w_ready_o depends only on registered
// state, so valid may wait for ready without a combinational loop.
//
// Optional feature: define ALPU_XRX_BYPASS_EN to let read lookups also see
// writes that are accepted in the same cycle.
module alpu_xrx_cache #(
  parameter int N_WCH  = 2,
  parameter int N_RD   = 2,
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [N_WCH-1:0]              w_valid_i,
  input  logic [N_WCH*ADDR_W-1:0]       w_addr_i,
  input  logic [N_WCH*DATA_W-1:0]       w_data_i,
  output logic [N_WCH-1:0]              w_ready_o,
  input  logic [N_RD-1:0]               r_req_i,
  input  logic [N_RD*ADDR_W-1:0]        r_addr_i,
  input  logic [N_RD-1:0]               r_consume_i,
  output logic [N_RD*DATA_W-1:0]        r_data_o,
  output logic [N_RD-1:0]               r_hit_o,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy_o,
  output logic                          err_o
);

  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int PTR_W = (N_WCH > 1) ? $clog2(N_WCH) : 1;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]  rr_q, rr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              err_q, err_d;

  logic [N_WCH-1:0]  w_acc;
  logic [N_WCH-1:0]  w_kill;      // accepted writes absorbed by a bypass consume
  logic [DEPTH-1:0]  st_sel [N_RD]; // one-hot stored-entry match per read port

  // Readiness: the channel at round-robin rank r is ready while r < free slots.
  always_comb begin
    w_ready_o = '0;
    for (int k = 0; k < N_WCH; k++) begin
      w_ready_o[k] = (((k - int'(rr_q) + N_WCH) % N_WCH) < (DEPTH - int'(occ_q)));
    end
  end

  assign w_acc = w_valid_i & w_ready_o;

  // CAM lookup per read port; the lowest matching index wins.
  always_comb begin
    logic found;
    r_hit_o  = '0;
    r_data_o = '0;
    w_kill   = '0;
    for (int j = 0; j < N_RD; j++) begin
      st_sel[j] = '0;
      found     = 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
        if (!found && valid_q[e] && (addr_q[e] == r_addr_i[j*ADDR_W +: ADDR_W])) begin
          found        = 1'b1;
          st_sel[j][e] = 1'b1;
          if (r_req_i[j]) r_data_o[j*DATA_W +: DATA_W] = data_q[e];
        end
      end
`ifdef ALPU_XRX_BYPASS_EN
      // No stored entry: the lowest-rank accepted write to this address supplies data.
      if (!found) begin
        for (int r = 0; r < N_WCH; r++) begin
          if (!found && w_acc[(int'(rr_q) + r) % N_WCH] &&
              (w_addr_i[((int'(rr_q) + r) % N_WCH)*ADDR_W +: ADDR_W] == r_addr_i[j*ADDR_W +: ADDR_W])) begin
            found = 1'b1;
            if (r_req_i[j]) r_data_o[j*DATA_W +: DATA_W] = w_data_i[((int'(rr_q) + r) % N_WCH)*DATA_W +: DATA_W];
          end
        end
        // A consumed bypass hit means none of the same-address writes allocate.
        if (found && r_req_i[j] && r_consume_i[j]) begin
          for (int k = 0; k < N_WCH; k++) begin
            if (w_acc[k] && (w_addr_i[k*ADDR_W +: ADDR_W] == r_addr_i[j*ADDR_W +: ADDR_W])) w_kill[k] = 1'b1;
          end
        end
      end
`endif
      r_hit_o[j] = r_req_i[j] & found;
    end
  end

  // Next-state: consumes first, then rank-ordered writes (a write re-validates its entry).
  always_comb begin
    logic [DEPTH-1:0] taken;
    logic             dup;
    logic             placed;
    int               ch;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rr_d    = rr_q;
    err_d   = err_q;
    occ_d   = '0;
    taken   = '0;
    dup     = 1'b0;
    placed  = 1'b0;
    ch      = 0;
    for (int j = 0; j < N_RD; j++) begin
      if (r_consume_i[j] && !r_req_i[j]) err_d = 1'b1;
      if (r_consume_i[j] && r_req_i[j]) valid_d = valid_d & ~st_sel[j];
    end
    for (int r = 0; r < N_WCH; r++) begin
      ch = (int'(rr_q) + r) % N_WCH;
      if (w_acc[ch]) begin
        rr_d = PTR_W'((ch + 1) % N_WCH);
        dup  = 1'b0;
        for (int r2 = 0; r2 < N_WCH; r2++) begin
          if ((r2 < r) && w_acc[(int'(rr_q) + r2) % N_WCH] &&
              (w_addr_i[((int'(rr_q) + r2) % N_WCH)*ADDR_W +: ADDR_W] == w_addr_i[ch*ADDR_W +: ADDR_W]))
            dup = 1'b1;
        end
        if (dup) begin
          err_d = 1'b1;
        end else if (!w_kill[ch]) begin
          placed = 1'b0;
          for (int e = 0; e < DEPTH; e++) begin
            if (!placed && valid_q[e] && (addr_q[e] == w_addr_i[ch*ADDR_W +: ADDR_W])) begin
              placed     = 1'b1;
              valid_d[e] = 1'b1;
              data_d[e]  = w_data_i[ch*DATA_W +: DATA_W];
            end
          end
          for (int e = 0; e < DEPTH; e++) begin
            if (!placed && !valid_q[e] && !taken[e]) begin
              placed     = 1'b1;
              taken[e]   = 1'b1;
              valid_d[e] = 1'b1;
              addr_d[e]  = w_addr_i[ch*ADDR_W +: ADDR_W];
              data_d[e]  = w_data_i[ch*DATA_W +: DATA_W];
            end
          end
        end
      end
    end
    for (int e = 0; e < DEPTH; e++) occ_d = occ_d + OCC_W'(valid_d[e]);
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      rr_q    <= '0;
      occ_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rr_q    <= rr_d;
      occ_q   <= occ_d;
      err_q   <= err_d;
    end
  end

  // Entry payload; meaningful only while the matching valid bit is set.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign occupancy_o = occ_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_alpu_xrx_cache.sv
// Testbench for alpu_xrx_cache: directed vectors, an address-keyed reference
// model, a per-cycle compare process and hand-computed literal expectations.
module tb_alpu_xrx_cache;
  localparam int N_WCH  = 2;
  localparam int N_RD   = 2;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int OCC_W  = $clog2(DEPTH+1);

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b1;
  logic [N_WCH-1:0]        w_valid;
  logic [N_WCH*ADDR_W-1:0] w_addr;
  logic [N_WCH*DATA_W-1:0] w_data;
  logic [N_WCH-1:0]        w_ready;
  logic [N_RD-1:0]         r_req, r_consume, r_hit;
  logic [N_RD*ADDR_W-1:0]  r_addr;
  logic [N_RD*DATA_W-1:0]  r_data;
  logic [OCC_W-1:0]        occupancy;
  logic                    err;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  alpu_xrx_cache #(.N_WCH(N_WCH), .N_RD(N_RD), .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .w_valid_i(w_valid), .w_addr_i(w_addr), .w_data_i(w_data), .w_ready_o(w_ready),
    .r_req_i(r_req), .r_addr_i(r_addr), .r_consume_i(r_consume),
    .r_data_o(r_data), .r_hit_o(r_hit), .occupancy_o(occupancy), .err_o(err)
  );

  // Clock and watchdog
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stored contents keyed by address, plus rr pointer and error flag.
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  int rr_m = 0;
  bit err_m = 1'b0;

  function automatic logic [ADDR_W-1:0] wa(int k); return w_addr[k*ADDR_W +: ADDR_W]; endfunction
  function automatic logic [DATA_W-1:0] wd(int k); return w_data[k*DATA_W +: DATA_W]; endfunction
  function automatic logic [ADDR_W-1:0] ra(int j); return r_addr[j*ADDR_W +: ADDR_W]; endfunction
  function automatic bit m_ready(int k);
    return ((k - rr_m + N_WCH) % N_WCH) < (DEPTH - mem.num());
  endfunction
  function automatic bit m_acc(int k); return w_valid[k] && m_ready(k); endfunction

  // 0 = miss, 1 = stored hit, 2 = same-cycle write hit
  function automatic int m_lookup(int j, output logic [DATA_W-1:0] d);
    d = '0;
    if (!r_req[j]) return 0;
    if (mem.exists(ra(j))) begin
      d = mem[ra(j)];
      return 1;
    end
`ifdef ALPU_XRX_BYPASS_EN
    for (int r = 0; r < N_WCH; r++) begin
      if (m_acc((rr_m + r) % N_WCH) && wa((rr_m + r) % N_WCH) == ra(j)) begin
        d = wd((rr_m + r) % N_WCH);
        return 2;
      end
    end
`endif
    return 0;
  endfunction

  // Model update at each clock edge
  always @(posedge clk or negedge reset_n) begin : model_upd
    bit del  [logic [ADDR_W-1:0]];
    bit kill [logic [ADDR_W-1:0]];
    bit seen [logic [ADDR_W-1:0]];
    bit acc  [N_WCH];
    int last;
    int kind;
    int k;
    logic [DATA_W-1:0] d;
    if (!reset_n) begin
      mem.delete();
      rr_m  = 0;
      err_m = 1'b0;
    end else begin
      del.delete(); kill.delete(); seen.delete();
      last = -1;
      for (int i = 0; i < N_WCH; i++) acc[i] = m_acc(i);
      for (int j = 0; j < N_RD; j++) begin
        if (r_consume[j] && !r_req[j]) err_m = 1'b1;
        if (r_consume[j]) begin
          kind = m_lookup(j, d);
          if (kind == 1) del[ra(j)] = 1'b1;
          else if (kind == 2) kill[ra(j)] = 1'b1;
        end
      end
      for (int r = 0; r < N_WCH; r++) begin
        k = (rr_m + r) % N_WCH;
        if (acc[k]) begin
          last = k;
          if (seen.exists(wa(k))) err_m = 1'b1;
          else begin
            seen[wa(k)] = 1'b1;
            if (!kill.exists(wa(k))) mem[wa(k)] = wd(k);
          end
        end
      end
      foreach (del[a]) if (!seen.exists(a)) mem.delete(a);
      if (last >= 0) rr_m = (last + 1) % N_WCH;
    end
  end

  // Per-cycle compare against the model, on the falling edge
  int cmp_kind;
  logic [DATA_W-1:0] cmp_d;
  always @(negedge clk) begin
    if (check_en) begin
      for (int k = 0; k < N_WCH; k++) chk($sformatf("w_ready[%0d]", k), 32'(w_ready[k]), 32'(m_ready(k)));
      for (int j = 0; j < N_RD; j++) begin
        cmp_kind = m_lookup(j, cmp_d);
        chk($sformatf("r_hit[%0d]", j), 32'(r_hit[j]), 32'(cmp_kind != 0));
        chk($sformatf("r_data[%0d]", j), 32'(r_data[j*DATA_W +: DATA_W]), 32'(cmp_d));
      end
      chk("occupancy", 32'(occupancy), 32'(mem.num()));
      chk("err", 32'(err), 32'(err_m));
    end
  end

  // Driver tasks
  task automatic idle();
    w_valid = '0; w_addr = '0; w_data = '0;
    r_req = '0; r_addr = '0; r_consume = '0;
  endtask
  task automatic wr(input int k, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    w_valid[k] = 1'b1;
    w_addr[k*ADDR_W +: ADDR_W] = a;
    w_data[k*DATA_W +: DATA_W] = d;
  endtask
  task automatic rd(input int j, input logic [ADDR_W-1:0] a, input bit cons);
    r_req[j] = 1'b1;
    r_addr[j*ADDR_W +: ADDR_W] = a;
    r_consume[j] = cons;
  endtask
  task automatic tick();
    @(posedge clk); #2; idle();
  endtask
  task automatic at_sample();
    @(negedge clk); #1;
  endtask

  logic [ADDR_W-1:0] stored_q[$];
  int wins [N_WCH];

  initial begin
    idle();
    check_en = 1'b1;
    #1 reset_n = 1'b0;
    at_sample();
    chk("reset occupancy", 32'(occupancy), 0);
    chk("reset err", 32'(err), 0);
    chk("reset ready", 32'(w_ready), 32'h3);
    chk("reset hit", 32'(r_hit), 0);
    @(posedge clk); #2 reset_n = 1'b1;

    // Single write then read back next cycle
    wr(0, 8'h12, 16'hBEEF); tick();
    rd(0, 8'h12, 1'b0); at_sample();
    chk("t1 hit", 32'(r_hit[0]), 1);
    chk("t1 data", 32'(r_data[15:0]), 32'hBEEF);
    chk("t1 occupancy", 32'(occupancy), 1);
    tick();

    // Fill to DEPTH, confirm backpressure, free one slot
    wr(0, 8'h01, 16'h0101); wr(1, 8'h02, 16'h0202); tick();
    wr(0, 8'h03, 16'h0303); wr(1, 8'h04, 16'h0404); tick();
    wr(0, 8'h05, 16'h0505); wr(1, 8'h06, 16'h0606); at_sample();
    chk("full ready", 32'(w_ready), 0);
    chk("full occupancy", 32'(occupancy), 4);
    tick();
    rd(1, 8'h01, 1'b1); tick();
    at_sample();
    chk("after consume occupancy", 32'(occupancy), 3);
    chk("after consume ready", 32'(w_ready), 32'h1);
    tick();
    rd(0, 8'h12, 1'b1); rd(1, 8'h02, 1'b1); tick();
    rd(0, 8'h04, 1'b1); tick();
    at_sample();
    chk("drained occupancy", 32'(occupancy), 0);
    tick();

    // Fairness with one free slot per cycle
    wr(0, 8'h60, 16'h6060); wr(1, 8'h61, 16'h6161); tick();
    wr(0, 8'h62, 16'h6262); tick();
    stored_q = '{8'h60, 8'h61, 8'h62};
    wins = '{0, 0};
    for (int i = 0; i < 6; i++) begin
      wr(0, 8'(8'h90 + 2*i), 16'(16'h9000 + i));
      wr(1, 8'(8'h91 + 2*i), 16'(16'h9100 + i));
      rd(0, stored_q.pop_front(), 1'b1);
      for (int k = 0; k < N_WCH; k++) begin
        if (m_ready(k)) begin
          wins[k]++;
          stored_q.push_back(8'(8'h90 + 2*i + k));
        end
      end
      tick();
    end
    chk("fair ch0 wins", 32'(wins[0]), 3);
    chk("fair ch1 wins", 32'(wins[1]), 3);
    rd(0, stored_q.pop_front(), 1'b1); rd(1, stored_q.pop_front(), 1'b1); tick();
    rd(0, stored_q.pop_front(), 1'b1); tick();

    // Same-address overwrite merges
    wr(0, 8'h20, 16'h1111); tick();
    wr(1, 8'h20, 16'h2222); tick();
    rd(0, 8'h20, 1'b0); at_sample();
    chk("merge hit", 32'(r_hit[0]), 1);
    chk("merge data", 32'(r_data[15:0]), 32'h2222);
    chk("merge occupancy", 32'(occupancy), 1);
    tick();

    // Write and consume of the same address: write wins
    wr(0, 8'h30, 16'h3333); tick();
    wr(0, 8'h30, 16'h4444); rd(1, 8'h30, 1'b1); tick();
    rd(1, 8'h30, 1'b0); at_sample();
    chk("wr+cons hit", 32'(r_hit[1]), 1);
    chk("wr+cons data", 32'(r_data[31:16]), 32'h4444);
    chk("wr+cons occupancy", 32'(occupancy), 2);
    tick();

    // Two channels writing one address: rank-0 (ch1 here) data kept, err set
    wr(0, 8'h40, 16'hAAAA); wr(1, 8'h40, 16'hBBBB); at_sample();
    chk("dup err before", 32'(err), 0);
    tick();
    rd(0, 8'h40, 1'b0); at_sample();
    chk("dup err", 32'(err), 1);
    chk("dup data", 32'(r_data[15:0]), 32'hBBBB);
    chk("dup occupancy", 32'(occupancy), 3);
    tick();

    // Asynchronous reset mid-operation
    wr(0, 8'h70, 16'h7070); reset_n = 1'b0; #1;
    chk("async reset occupancy", 32'(occupancy), 0);
    chk("async reset err", 32'(err), 0);
    @(posedge clk); #2 reset_n = 1'b1; idle();

    // Consume without request flags an error
    r_consume[1] = 1'b1; tick();
    at_sample();
    chk("consume-no-req err", 32'(err), 1);
    tick();

`ifdef ALPU_XRX_BYPASS_EN
    wr(0, 8'h56, 16'h5A5A); rd(0, 8'h56, 1'b1); at_sample();
    chk("bypass consume hit", 32'(r_hit[0]), 1);
    tick();
    at_sample();
    chk("bypass consume occupancy", 32'(occupancy), 0);
    tick();
    wr(0, 8'h55, 16'hA5A5); rd(0, 8'h55, 1'b0); at_sample();
    chk("bypass hit", 32'(r_hit[0]), 1);
    chk("bypass data", 32'(r_data[15:0]), 32'hA5A5);
    tick();
    at_sample();
    chk("bypass occupancy", 32'(occupancy), 1);
`else
    wr(0, 8'h57, 16'h5757); rd(0, 8'h57, 1'b0); at_sample();
    chk("no bypass same-cycle miss", 32'(r_hit[0]), 0);
    tick();
    rd(0, 8'h57, 1'b0); at_sample();
    chk("no bypass next-cycle data", 32'(r_data[15:0]), 32'h5757);
`endif
    tick();

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
